rgb_matrix_scanner: RTL and testbench

Parametrised successor to the single-colour column scanner. It drives a ROWS x COLS RGB LED matrix with active-low column selects and per-channel PWM at DEPTH bits per colour. An internal double-buffered frame store has a pixel write port, and bank swaps are frame-synchronous. It sits between the game logic, which writes pixels, and the matrix pins.

---
 rtl/rgb_matrix_scanner.sv | 170 +++++++++++++++++
 tb/tb_rgb_matrix_scanner.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_matrix_scanner.sv
// rtl/rgb_matrix_scanner.sv - RGB LED matrix column scanner with PWM and double-buffered frame store
module rgb_matrix_scanner #(
  parameter int ROWS  = 8,
  parameter int COLS  = 12,
  parameter int DEPTH = 4,
  parameter int TICK  = 1,
  parameter int BLANK = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ENABLE,
  input  logic                          WR_EN,
  input  logic [$clog2(ROWS*COLS)-1:0]  WR_ADDR,
  input  logic [3*DEPTH-1:0]            WR_DATA,
  input  logic                          SWAP_REQ,
  output logic                          SWAP_PEND,
  output logic                          FRAME_START,
  output logic [ROWS-1:0]               LED_R,
  output logic [ROWS-1:0]               LED_G,
  output logic [ROWS-1:0]               LED_B,
  output logic [COLS-1:0]               LED_SELC,
  output logic                          LED_RST
);

  localparam int NPIX = ROWS * COLS;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int BW   = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int TW   = (TICK  > 1) ? $clog2(TICK)  : 1;
  localparam int DW   = 3 * DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [DEPTH-1:0]  step_q, step_d;
  logic              front_q, front_d;
  logic              pend_q, pend_d;
  logic              fs_q, fs_d;
  logic [ROWS-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [COLS-1:0]   selc_q, selc_d;
  logic              ledrst_q;

  logic [DW-1:0]     mem_q [2][NPIX];
  logic [DW-1:0]     pix;
  logic [AW-1:0]     rd_addr;

  logic on_last, frame_end, swap_now;

  assign on_last   = (state_q == S_ON) && (tick_q == TW'(TICK - 1)) && (step_q == '1);
  assign frame_end = on_last && (col_q == CW'(COLS - 1));
  assign swap_now  = pend_q && ((state_q == S_IDLE) || frame_end);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      blank_q  <= '0;
      tick_q   <= '0;
      step_q   <= '0;
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      fs_q     <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      selc_q   <= '1;
      ledrst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      blank_q  <= blank_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      front_q  <= front_d;
      pend_q   <= pend_d;
      fs_q     <= fs_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      selc_q   <= selc_d;
      ledrst_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    blank_d = blank_q;
    tick_d  = tick_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d = S_BLANK;
          col_d   = '0;
          blank_d = '0;
        end
      end
      S_BLANK: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
          col_d   = '0;
        end else if (blank_q == BW'(BLANK - 1)) begin
          state_d = S_ON;
          tick_d  = '0;
          step_d  = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      S_ON: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
          col_d   = '0;
        end else if (on_last) begin
          state_d = S_BLANK;
          blank_d = '0;
          col_d   = frame_end ? '0 : col_q + 1'b1;
        end else if (tick_q == TW'(TICK - 1)) begin
          tick_d  = '0;
          step_d  = step_q + 1'b1;
        end else begin
          tick_d  = tick_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving on the swap edge is absorbed by that swap.
    front_d = front_q ^ swap_now;
    pend_d  = swap_now ? 1'b0 : (pend_q | SWAP_REQ);
  end

  // Output registers are loaded from next-state values so they line up with the state.
  always_comb begin
    fs_d    = ENABLE && ((state_q == S_IDLE) || frame_end);
    selc_d  = '1;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    pix     = '0;
    rd_addr = '0;
    if (state_d == S_ON) begin
      selc_d[col_d] = 1'b0;
      for (int j = 0; j < ROWS; j++) begin
        rd_addr = AW'(col_d) + AW'(COLS * j);
        pix     = mem_q[front_d][rd_addr];
        r_d[j]  = pix[3*DEPTH-1 -: DEPTH] > step_d;
        g_d[j]  = pix[2*DEPTH-1 -: DEPTH] > step_d;
        b_d[j]  = pix[DEPTH-1:0] > step_d;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (WR_EN && ({1'b0, WR_ADDR} < (AW + 1)'(NPIX)))
      mem_q[~front_q][WR_ADDR] <= WR_DATA;
  end

  assign SWAP_PEND   = pend_q;
  assign FRAME_START = fs_q;
  assign LED_R       = r_q;
  assign LED_G       = g_q;
  assign LED_B       = b_q;
  assign LED_SELC    = selc_q;
  assign LED_RST     = ledrst_q;

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// tb/tb_rgb_matrix_scanner.sv - directed self-checking bench for rgb_matrix_scanner
module tb_rgb_matrix_scanner;

  logic        CLK, RST;
  logic        ENABLE, WR_EN, SWAP_REQ;
  logic [6:0]  WR_ADDR;
  logic [11:0] WR_DATA;
  logic        SWAP_PEND, FRAME_START, LED_RST;
  logic [7:0]  LED_R, LED_G, LED_B;
  logic [11:0] LED_SELC;

  logic        ENABLE2, WR_EN2, SWAP_REQ2;
  logic [2:0]  WR_ADDR2;
  logic [5:0]  WR_DATA2;
  logic        SWAP_PEND2, FRAME_START2, LED_RST2;
  logic [1:0]  LED_R2, LED_G2, LED_B2;
  logic [2:0]  LED_SELC2;

  int tests = 0;
  int fails = 0;

  logic [11:0] img [2][96];
  logic        front;
  logic        pend;

  rgb_matrix_scanner dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .SWAP_REQ(SWAP_REQ), .SWAP_PEND(SWAP_PEND),
    .FRAME_START(FRAME_START), .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
    .LED_SELC(LED_SELC), .LED_RST(LED_RST)
  );

  rgb_matrix_scanner #(.ROWS(2), .COLS(3), .DEPTH(2), .TICK(3), .BLANK(2)) dut2 (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE2), .WR_EN(WR_EN2), .WR_ADDR(WR_ADDR2),
    .WR_DATA(WR_DATA2), .SWAP_REQ(SWAP_REQ2), .SWAP_PEND(SWAP_PEND2),
    .FRAME_START(FRAME_START2), .LED_R(LED_R2), .LED_G(LED_G2), .LED_B(LED_B2),
    .LED_SELC(LED_SELC2), .LED_RST(LED_RST2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Steps the main DUT through frame cycles c0..c0+n-1 (c=0 is the FRAME_START cycle).
  task automatic run_frame(input int c0, input int n, input int mode);
    for (int c = c0; c < c0 + n; c++) begin
      int          col, ph;
      logic [11:0] e_selc, pix;
      logic [7:0]  er, eg, eb;
      logic        req, swp;
      col = (c / 20) % 12;
      ph  = c % 20;
      e_selc = '1; er = '0; eg = '0; eb = '0;
      if (ph >= 4) begin
        e_selc[col] = 1'b0;
        for (int j = 0; j < 8; j++) begin
          pix   = img[front][col + 12 * j];
          er[j] = pix[11:8] > 4'(ph - 4);
          eg[j] = pix[7:4]  > 4'(ph - 4);
          eb[j] = pix[3:0]  > 4'(ph - 4);
        end
      end
      tests++;
      if (LED_SELC !== e_selc) begin
        fails++;
        $display("FAIL scan_selc c=%0d got %h exp %h", c, LED_SELC, e_selc);
      end
      tests++;
      if (FRAME_START !== (c % 240 == 0)) begin
        fails++;
        $display("FAIL scan_frame_start c=%0d got %b exp %b", c, FRAME_START, (c % 240 == 0));
      end
      tests++;
      if ({LED_R, LED_G, LED_B} !== {er, eg, eb}) begin
        fails++;
        $display("FAIL scan_rgb c=%0d got %h/%h/%h exp %h/%h/%h", c, LED_R, LED_G, LED_B, er, eg, eb);
      end
      tests++;
      if (SWAP_PEND !== pend) begin
        fails++;
        $display("FAIL scan_swap_pend c=%0d got %b exp %b", c, SWAP_PEND, pend);
      end
      req = 1'b0;
      WR_EN = 1'b0;
      SWAP_REQ = 1'b0;
      if (mode == 1 && c == 50) begin
        WR_EN = 1'b1; WR_ADDR = 7'd13; WR_DATA = 12'h50F; SWAP_REQ = 1'b1; req = 1'b1;
        img[~front][13] = 12'h50F;
      end
      if (mode == 1 && c == 51) begin
        WR_EN = 1'b1; WR_ADDR = 7'd32; WR_DATA = 12'hFFF;
        img[~front][32] = 12'hFFF;
      end
      swp = pend && (c % 240 == 239);
      tick;
      if (swp) front = ~front;
      pend = swp ? 1'b0 : (pend | req);
    end
    WR_EN = 1'b0;
    SWAP_REQ = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    tick;
    tests++;
    if ({LED_SELC, LED_R, LED_G, LED_B} !== {12'hFFF, 24'h0}) begin
      fails++;
      $display("FAIL reset_outputs got %h/%h/%h/%h exp fff/00/00/00", LED_SELC, LED_R, LED_G, LED_B);
    end
    tests++;
    if ({LED_RST, SWAP_PEND, FRAME_START} !== 3'b100) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 100", {LED_RST, SWAP_PEND, FRAME_START});
    end
    RST = 1'b0;
    tick;
    tests++;
    if (LED_RST !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_led_rst got %b exp 0", LED_RST);
    end
    front = 1'b0;
    pend  = 1'b0;
  endtask

  task automatic test_small;
    int r0_on, b0_on, other_on;
    for (int a = 0; a < 6; a++) begin
      WR_EN2 = 1'b1; WR_ADDR2 = 3'(a); WR_DATA2 = '0; tick;
    end
    WR_EN2 = 1'b0; SWAP_REQ2 = 1'b1; tick; SWAP_REQ2 = 1'b0; tick;
    for (int a = 0; a < 6; a++) begin
      WR_EN2 = 1'b1; WR_ADDR2 = 3'(a); WR_DATA2 = (a == 0) ? 6'h23 : 6'h00; tick;
    end
    WR_EN2 = 1'b0; SWAP_REQ2 = 1'b1; tick; SWAP_REQ2 = 1'b0; tick;
    ENABLE2 = 1'b1;
    tick;
    r0_on = 0; b0_on = 0; other_on = 0;
    for (int c = 0; c < 42; c++) begin
      if (c == 0) begin
        tests++;
        if (FRAME_START2 !== 1'b1) begin
          fails++;
          $display("FAIL small_frame_start0 got %b exp 1", FRAME_START2);
        end
      end
      if (c == 1) begin
        tests++;
        if (LED_SELC2 !== 3'b111) begin
          fails++;
          $display("FAIL small_blank_selc got %b exp 111", LED_SELC2);
        end
      end
      if (c == 2) begin
        tests++;
        if (LED_SELC2 !== 3'b110) begin
          fails++;
          $display("FAIL small_col0_selc got %b exp 110", LED_SELC2);
        end
      end
      if (c == 16) begin
        tests++;
        if (LED_SELC2 !== 3'b101) begin
          fails++;
          $display("FAIL small_col1_selc got %b exp 101", LED_SELC2);
        end
      end
      r0_on += int'(LED_R2[0]);
      b0_on += int'(LED_B2[0]);
      other_on += int'(LED_R2[1]) + int'(LED_B2[1]) + int'(|LED_G2);
      tick;
    end
    tests++;
    if (FRAME_START2 !== 1'b1) begin
      fails++;
      $display("FAIL small_frame_period got %b exp 1 at cycle 42", FRAME_START2);
    end
    tests++;
    if (r0_on != 6) begin
      fails++;
      $display("FAIL small_red_duty got %0d exp 6", r0_on);
    end
    tests++;
    if (b0_on != 9) begin
      fails++;
      $display("FAIL small_blue_duty got %0d exp 9", b0_on);
    end
    tests++;
    if (other_on != 0) begin
      fails++;
      $display("FAIL small_other_lines got %0d exp 0", other_on);
    end
    ENABLE2 = 1'b0;
  endtask

  task automatic test_init_store;
    for (int a = 0; a < 96; a++) begin
      WR_EN = 1'b1; WR_ADDR = 7'(a); WR_DATA = 12'h000; tick;
      img[~front][a] = 12'h000;
    end
    WR_ADDR = 7'd100; WR_DATA = 12'hFFF; tick;
    WR_EN = 1'b0; SWAP_REQ = 1'b1; tick;
    SWAP_REQ = 1'b0;
    tests++;
    if (SWAP_PEND !== 1'b1) begin
      fails++;
      $display("FAIL idle_swap_pend_set got %b exp 1", SWAP_PEND);
    end
    tick;
    front = ~front;
    tests++;
    if (SWAP_PEND !== 1'b0) begin
      fails++;
      $display("FAIL idle_swap_exec got %b exp 0", SWAP_PEND);
    end
    for (int a = 0; a < 96; a++) begin
      WR_EN = 1'b1; WR_ADDR = 7'(a); WR_DATA = 12'h000; tick;
      img[~front][a] = 12'h000;
    end
    WR_EN = 1'b0;
  endtask

  task automatic test_scan;
    ENABLE = 1'b1;
    tick;
    run_frame(0, 480, 0);
  endtask

  task automatic test_swap_mid;
    run_frame(0, 240, 1);
  endtask

  task automatic test_pixel;
    run_frame(0, 24, 0);
    for (int s = 0; s < 16; s++) begin
      tests++;
      if (LED_SELC !== 12'hFFD) begin
        fails++;
        $display("FAIL pixel_selc s=%0d got %h exp ffd", s, LED_SELC);
      end
      tests++;
      if ({LED_R, LED_G, LED_B} !== {(s < 5) ? 8'h02 : 8'h00, 8'h00, (s < 15) ? 8'h02 : 8'h00}) begin
        fails++;
        $display("FAIL pixel_rgb s=%0d got %h/%h/%h", s, LED_R, LED_G, LED_B);
      end
      tick;
    end
    run_frame(40, 200, 0);
  endtask

  task automatic test_disable;
    run_frame(0, 100, 0);
    WR_EN = 1'b1; WR_ADDR = 7'd0; WR_DATA = 12'h300; SWAP_REQ = 1'b1;
    img[~front][0] = 12'h300;
    tick;
    WR_EN = 1'b0; SWAP_REQ = 1'b0;
    tests++;
    if (SWAP_PEND !== 1'b1) begin
      fails++;
      $display("FAIL disable_pend_set got %b exp 1", SWAP_PEND);
    end
    for (int k = 0; k < 9; k++) tick;
    tests++;
    if (LED_SELC !== 12'hFDF) begin
      fails++;
      $display("FAIL disable_col5_on got %h exp fdf", LED_SELC);
    end
    ENABLE = 1'b0;
    tick;
    tests++;
    if ({LED_SELC, LED_R, LED_G, LED_B, FRAME_START} !== {12'hFFF, 24'h0, 1'b0}) begin
      fails++;
      $display("FAIL disable_blank got %h/%h/%h/%h fs=%b", LED_SELC, LED_R, LED_G, LED_B, FRAME_START);
    end
    tests++;
    if (SWAP_PEND !== 1'b1) begin
      fails++;
      $display("FAIL disable_pend_hold got %b exp 1", SWAP_PEND);
    end
    tick;
    front = ~front;
    pend  = 1'b0;
    tests++;
    if (SWAP_PEND !== 1'b0) begin
      fails++;
      $display("FAIL disable_idle_swap got %b exp 0", SWAP_PEND);
    end
    ENABLE = 1'b1;
    tick;
    run_frame(0, 240, 0);
  endtask

  task automatic test_reset_mid;
    run_frame(0, 30, 0);
    SWAP_REQ = 1'b1;
    tick;
    SWAP_REQ = 1'b0;
    tests++;
    if (SWAP_PEND !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pend_set got %b exp 1", SWAP_PEND);
    end
    #2;
    RST = 1'b1;
    #1;
    tests++;
    if ({LED_SELC, LED_R, LED_G, LED_B} !== {12'hFFF, 24'h0}) begin
      fails++;
      $display("FAIL rstmid_blank got %h/%h/%h/%h", LED_SELC, LED_R, LED_G, LED_B);
    end
    tests++;
    if ({LED_RST, SWAP_PEND} !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_ctrl got %b exp 10", {LED_RST, SWAP_PEND});
    end
    tick;
    RST = 1'b0;
    front = 1'b0;
    pend  = 1'b0;
    tick;
    tests++;
    if (LED_RST !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_led_rst got %b exp 0", LED_RST);
    end
    run_frame(0, 240, 0);
  endtask

  initial begin
    RST = 1'b1;
    ENABLE = 1'b0; WR_EN = 1'b0; SWAP_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    ENABLE2 = 1'b0; WR_EN2 = 1'b0; SWAP_REQ2 = 1'b0; WR_ADDR2 = '0; WR_DATA2 = '0;
    front = 1'b0;
    pend  = 1'b0;
    test_reset;
    test_small;
    test_init_store;
    test_scan;
    test_swap_mid;
    test_pixel;
    test_disable;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
